// File: rtl/fifo_packer_pkg.sv
// rtl/fifo_packer_pkg.sv - shared constants and elaboration helpers for fifo_word_packer
package fifo_packer_pkg;

    localparam int TIMER_W = 8;

    function automatic int lane_bits(input int ratio);
        case (ratio)
            2:       return 1;
            4:       return 2;
            8:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit ratio_legal(input int ratio);
        return (ratio == 2) || (ratio == 4) || (ratio == 8);
    endfunction

endpackage

// File: rtl/packer_out_reg.sv
// rtl/packer_out_reg.sv - output beat holding register with valid/ready hold logic
module packer_out_reg
    import fifo_packer_pkg::*;
#(
    parameter int W     = 8,
    parameter int RATIO = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [RATIO*W-1:0] load_data,
    input  logic [RATIO-1:0]   load_keep,
    input  logic               m_ready,
    output logic               m_valid,
    output logic [RATIO*W-1:0] m_data,
    output logic [RATIO-1:0]   m_keep,
    output logic               out_free
);

    assign out_free = !m_valid || m_ready;

    // A load always wins over a completing transfer so back-to-back beats need no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs RATIO show-ahead FIFO words per beat; partial flush under PACKER_FLUSH_EN
module fifo_word_packer
    import fifo_packer_pkg::*;
#(
    parameter int W       = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [W-1:0]       fifo_rd_data,
    output logic               fifo_rd_en,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [RATIO*W-1:0] m_data,
    output logic [RATIO-1:0]   m_keep
);

    localparam int             CW   = lane_bits(RATIO);
    localparam logic [CW-1:0]  LAST = CW'(RATIO - 1);

    generate
        if (!ratio_legal(RATIO) || TIMEOUT < 2 || TIMEOUT >= (1 << TIMER_W)) begin : g_bad_cfg
            $error("fifo_word_packer: illegal RATIO or TIMEOUT");
        end
    endgenerate

    logic [CW-1:0]            cnt;
    logic [(RATIO-1)*W-1:0]   acc;
    logic                     out_free;
    logic                     load_full;
    logic                     flush;
    logic                     load;
    logic [RATIO*W-1:0]       load_data;
    logic [RATIO-1:0]         load_keep;

    // Reset gates the pop so a FIFO that is non-empty during reset is never drained.
    assign fifo_rd_en = !reset && !fifo_empty && ((cnt != LAST) || out_free);
    assign load_full  = fifo_rd_en && (cnt == LAST);
    assign load       = load_full || flush;

`ifdef PACKER_FLUSH_EN
    logic [TIMER_W-1:0]       timer;
    logic [(RATIO-1)*W-1:0]   flush_data;
    logic [RATIO-2:0]         flush_keep;

    assign flush = !fifo_rd_en && (cnt != '0) && (timer == TIMER_W'(TIMEOUT)) && out_free;

    // Lanes at or above cnt may hold words of an earlier beat and must be zeroed.
    always_comb begin
        flush_data = '0;
        flush_keep = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (i < int'(cnt)) begin
                flush_data[i*W +: W] = acc[i*W +: W];
                flush_keep[i]        = 1'b1;
            end
        end
    end

    always_comb begin
        load_data = {fifo_rd_data, acc};
        load_keep = '1;
        if (flush) begin
            load_data = {{W{1'b0}}, flush_data};
            load_keep = {1'b0, flush_keep};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (fifo_rd_en || (cnt == '0) || flush) begin
            timer <= '0;
        end else if (timer != TIMER_W'(TIMEOUT)) begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign flush     = 1'b0;
    assign load_data = {fifo_rd_data, acc};
    assign load_keep = '1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
        end else if (fifo_rd_en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                acc[int'(cnt)*W +: W] <= fifo_rd_data;
                cnt                   <= cnt + 1'b1;
            end
        end else if (flush) begin
            cnt <= '0;
        end
    end

    packer_out_reg #(
        .W     (W),
        .RATIO (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .out_free  (out_free)
    );

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - randomized self-checking bench against a queue-based packing model
module tb_fifo_word_packer;

    localparam int W       = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;
    localparam int BW      = RATIO * W;
`ifdef PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fifo_empty = 1'b1;
    logic [W-1:0]     fifo_rd_data = '0;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [BW-1:0]    m_data;
    logic [RATIO-1:0] m_keep;

    always #5 clk = ~clk;

    fifo_word_packer #(
        .W       (W),
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_keep       (m_keep)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: words the FIFO holds, words packed so far, and the pending beat.
    logic [W-1:0]     src_q[$];
    logic [W-1:0]     acc_q[$];
    logic [BW-1:0]    xfer_log[$];
    logic [RATIO-1:0] keep_log[$];
    bit               exp_valid = 1'b0;
    logic [BW-1:0]    exp_data  = '0;
    logic [RATIO-1:0] exp_keep  = '0;
    int               idle      = 0;
    int               ready_mode = 0;
    int               gap_pct    = 0;
    int               dut_pops   = 0;

    task automatic make_beat();
        exp_data = '0;
        exp_keep = '0;
        for (int i = 0; i < acc_q.size(); i++) begin
            exp_data[i*W +: W] = acc_q[i];
            exp_keep[i]        = 1'b1;
        end
        exp_valid = 1'b1;
        acc_q.delete();
    endtask

    // Called in the low clock phase; drives inputs, checks, advances the model, then waits one cycle.
    task automatic cycle();
        bit avail, rdy, exp_rd, out_free, do_flush;
        int acc_before;
        avail = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        rdy   = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(99) < 60);
        fifo_empty   = !avail;
        fifo_rd_data = avail ? src_q[0] : W'($urandom);
        m_ready      = rdy;
        #1;
        acc_before = acc_q.size();
        out_free   = !exp_valid || rdy;
        exp_rd     = avail && ((acc_before != RATIO - 1) || out_free);
        check("fifo_rd_en", fifo_rd_en, exp_rd);
        check("m_valid", m_valid, exp_valid);
        if (exp_valid) begin
            check("m_data", m_data, exp_data);
            check("m_keep", m_keep, exp_keep);
        end
        if (fifo_rd_en) dut_pops++;
        do_flush = FLUSH && !exp_rd && (acc_before != 0) && (idle == TIMEOUT) && out_free;
        if (exp_valid && rdy) begin
            xfer_log.push_back(m_data);
            keep_log.push_back(m_keep);
            exp_valid = 1'b0;
        end
        if (exp_rd) begin
            acc_q.push_back(src_q.pop_front());
            if (acc_q.size() == RATIO) make_beat();
        end
        if (do_flush) make_beat();
        if (exp_rd || acc_before == 0 || do_flush) idle = 0;
        else if (idle < TIMEOUT) idle++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        fifo_empty   = (src_q.size() == 0);
        fifo_rd_data = (src_q.size() > 0) ? src_q[0] : '0;
        m_ready      = 1'b1;
        acc_q.delete();
        exp_valid = 1'b0;
        idle      = 0;
        #1;
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_keep", m_keep, '0);
        @(negedge clk);
        #1;
        check("rst_rd_en_hold", fifo_rd_en, 1'b0);
        check("rst_m_data", m_data, '0);
        reset = 1'b0;
    endtask

    initial begin
        bit done;
        @(negedge clk);

        // Reset with a non-empty FIFO, then plain streaming of 0x01..0x08.
        for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
        do_reset();
        ready_mode = 0;
        gap_pct    = 0;
        dut_pops   = 0;
        run(12);
        check("stream_pops", dut_pops, 8);
        check("stream_nbeats", xfer_log.size(), 2);
        check("stream_beat0", xfer_log[0], 32'h04030201);
        check("stream_beat1", xfer_log[1], 32'h08070605);
        check("stream_keep0", keep_log[0], 4'hF);

        // Back-pressure: sink stalled, only 7 of 8 words may be popped.
        xfer_log.delete();
        keep_log.delete();
        for (int i = 1; i <= 8; i++) src_q.push_back(W'(8'h10 + i));
        ready_mode = 2;
        dut_pops   = 0;
        run(12);
        check("bp_pops_stalled", dut_pops, 7);
        ready_mode = 0;
        run(10);
        check("bp_pops_total", dut_pops, 8);
        check("bp_nbeats", xfer_log.size(), 2);
        check("bp_beat0", xfer_log[0], 32'h14131211);
        check("bp_beat1", xfer_log[1], 32'h18171615);

        // FIFO runs dry after two words, then resumes.
        xfer_log.delete();
        keep_log.delete();
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        run(6);
        check("dry_cnt", dut.cnt, 2);
        check("dry_no_beat", xfer_log.size(), 0);
        src_q.push_back(8'h03);
        src_q.push_back(8'h04);
        run(6);
        check("dry_beat", xfer_log[0], 32'h04030201);

        // Two words then idle: flushed as a partial beat, or held in a no-flush build.
        xfer_log.delete();
        keep_log.delete();
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        run(30);
`ifdef PACKER_FLUSH_EN
        check("flush_nbeats", xfer_log.size(), 1);
        check("flush_data", xfer_log[0], 32'h0000BBAA);
        check("flush_keep", keep_log[0], 4'h3);
`else
        check("noflush_nbeats", xfer_log.size(), 0);
        check("noflush_valid", m_valid, 1'b0);
        src_q.push_back(8'hCC);
        src_q.push_back(8'hDD);
        run(6);
        check("noflush_beat", xfer_log[0], 32'hDDCCBBAA);
`endif

        // Reset with two words packed: the next beat holds only post-reset words.
        xfer_log.delete();
        keep_log.delete();
        src_q.push_back(8'h51);
        src_q.push_back(8'h52);
        run(3);
        do_reset();
        for (int i = 1; i <= 4; i++) src_q.push_back(W'(8'h60 + i));
        run(8);
        check("rst_mid_nbeats", xfer_log.size(), 1);
        check("rst_mid_beat", xfer_log[0], 32'h64636261);

        // Random traffic with FIFO gaps and random sink stalls.
        ready_mode = 1;
        gap_pct    = 30;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 55) src_q.push_back(W'($urandom));
            cycle();
        end
        while (((src_q.size() + acc_q.size()) % RATIO) != 0) src_q.push_back(W'($urandom));
        ready_mode = 0;
        gap_pct    = 0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            cycle();
            done = (src_q.size() == 0) && (acc_q.size() == 0) && !exp_valid;
        end
        check("drain_done", done, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
